// File: rtl/multdiv_pkg.sv
// Shared definitions for the multdiv unit.
// Contents:
//   DIV_WIDTH    operand/result width of the signed divider
//   DIV_MIN      most negative operand (only operand whose magnitude needs WIDTH bits unsigned)
//   DIV_NEG_ONE  all-ones divisor (overflow when paired with DIV_MIN)
//   div_state_t  divider FSM state type plus its state constants
// Optional build macro: DIV_REMAINDER_EN adds the remainder fix-up state.
package multdiv_pkg;

   localparam int unsigned DIV_WIDTH   = 32;
   localparam logic [31:0] DIV_MIN     = 32'h8000_0000;
   localparam logic [31:0] DIV_NEG_ONE = 32'hFFFF_FFFF;

   typedef logic [2:0] div_state_t;

   localparam div_state_t StIdle = 3'd0;
   localparam div_state_t StNegA = 3'd1;
   localparam div_state_t StNegB = 3'd2;
   localparam div_state_t StIter = 3'd3;
   localparam div_state_t StNegQ = 3'd4;
   localparam div_state_t StDone = 3'd5;
`ifdef DIV_REMAINDER_EN
   localparam div_state_t StNegR = 3'd6;
`endif

endpackage

// File: rtl/div_step.sv
// One restoring-division step (purely combinational).
// Ports:
//   rem       in   WIDTH  partial remainder, always below divisor
//   quo       in   WIDTH  dividend bits still to shift in / quotient bits so far
//   divisor   in   WIDTH  divisor magnitude (may be 2^(WIDTH-1))
//   rem_next  out  WIDTH  partial remainder after this step
//   quo_next  out  WIDTH  quotient register after this step
module div_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quo_next
);

   logic [WIDTH:0] rem_shift;
   logic [WIDTH:0] trial;
   logic           keep;

   // rem < divisor <= 2^(WIDTH-1), so rem_shift < 2^WIDTH and the WIDTH+1 bit trial
   // difference never wraps: its top bit is exactly the borrow.
   assign rem_shift = {rem, quo[WIDTH-1]};
   assign trial     = rem_shift - {1'b0, divisor};
   assign keep      = ~trial[WIDTH];

   assign rem_next = keep ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
   assign quo_next = {quo[WIDTH-2:0], keep};

endmodule

// File: rtl/signed_div_sequencer.sv
// Multi-cycle signed divider controller. One shared conditional negator (~x+1) is
// time-multiplexed by state over: |A|, |B|, quotient sign fix-up (and remainder sign
// fix-up). 32 restoring iterations run in between. Quotient truncates toward zero.
// Optional build macro: DIV_REMAINDER_EN adds data_remainder (sign follows the dividend).
// Ports:
//   clock           in   1      rising-edge clock
//   reset           in   1      asynchronous active-high reset
//   ctrl_DIV        in   1      start request, sampled only when idle
//   data_operandA   in   WIDTH  dividend (two's complement)
//   data_operandB   in   WIDTH  divisor (two's complement)
//   data_result     out  WIDTH  quotient, held until the next completion
//   data_exception  out  1      divide-by-zero or MIN/-1 overflow, valid with data_resultRDY
//   data_resultRDY  out  1      one-cycle completion pulse
//   busy            out  1      high whenever not idle
//   data_remainder  out  WIDTH  remainder (DIV_REMAINDER_EN builds only)
module signed_div_sequencer
   import multdiv_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
`ifdef DIV_REMAINDER_EN
   ,
   output logic [WIDTH-1:0] data_remainder
`endif
);

   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LastStep = CNT_W'(WIDTH - 1);

   div_state_t       state_q, state_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;    // A, then |A|, then quotient bits
   logic [WIDTH-1:0] dvs_q, dvs_d;    // B, then |B|
   logic [WIDTH-1:0] rem_q, rem_d;    // partial remainder
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             quo_neg_q, quo_neg_d;
   logic             rem_neg_q, rem_neg_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             exc_q, exc_d;
`ifdef DIV_REMAINDER_EN
   logic [WIDTH-1:0] rmd_q, rmd_d;
`endif

   logic [WIDTH-1:0] neg_in, neg_out;
   logic             neg_en;
   logic [WIDTH-1:0] step_rem, step_quo;
   logic             div_zero, div_ovf;

   div_step #(
      .WIDTH (WIDTH)
   ) u_div_step (
      .rem      (rem_q),
      .quo      (dvd_q),
      .divisor  (dvs_q),
      .rem_next (step_rem),
      .quo_next (step_quo)
   );

   // Shared negator: the operand is chosen purely by state, one user per cycle.
   always_comb begin
      neg_in = '0;
      neg_en = 1'b0;
      case (state_q)
         StNegA: begin
            neg_in = dvd_q;
            neg_en = rem_neg_q;
         end
         StNegB: begin
            neg_in = dvs_q;
            neg_en = dvs_q[WIDTH-1];
         end
         StNegQ: begin
            neg_in = dvd_q;
            neg_en = quo_neg_q;
         end
`ifdef DIV_REMAINDER_EN
         StNegR: begin
            neg_in = rem_q;
            neg_en = rem_neg_q;
         end
`endif
         default: ;
      endcase
   end

   assign neg_out = neg_en ? (~neg_in + WIDTH'(1)) : neg_in;

   // Evaluated in NEG_B: dvd_q already holds |A| (|MIN| is MIN), dvs_q still holds raw B.
   assign div_zero = (dvs_q == '0);
   assign div_ovf  = (dvd_q == DIV_MIN) && (dvs_q == DIV_NEG_ONE);

   always_comb begin
      state_d   = state_q;
      dvd_d     = dvd_q;
      dvs_d     = dvs_q;
      rem_d     = rem_q;
      cnt_d     = cnt_q;
      quo_neg_d = quo_neg_q;
      rem_neg_d = rem_neg_q;
      result_d  = result_q;
      exc_d     = exc_q;
`ifdef DIV_REMAINDER_EN
      rmd_d     = rmd_q;
`endif
      case (state_q)
         StIdle: begin
            if (ctrl_DIV) begin
               dvd_d     = data_operandA;
               dvs_d     = data_operandB;
               quo_neg_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
               rem_neg_d = data_operandA[WIDTH-1];
               state_d   = StNegA;
            end
         end
         StNegA: begin
            dvd_d   = neg_out;
            state_d = StNegB;
         end
         StNegB: begin
            dvs_d = neg_out;
            if (div_zero || div_ovf) begin
               result_d = '0;
               exc_d    = 1'b1;
`ifdef DIV_REMAINDER_EN
               rmd_d    = '0;
`endif
               state_d  = StDone;
            end else begin
               rem_d   = '0;
               cnt_d   = '0;
               state_d = StIter;
            end
         end
         StIter: begin
            rem_d = step_rem;
            dvd_d = step_quo;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LastStep) begin
               state_d = StNegQ;
            end
         end
         StNegQ: begin
`ifdef DIV_REMAINDER_EN
            // Park the signed quotient so both results commit together on the next edge.
            dvd_d   = neg_out;
            state_d = StNegR;
`else
            result_d = neg_out;
            exc_d    = 1'b0;
            state_d  = StDone;
`endif
         end
`ifdef DIV_REMAINDER_EN
         StNegR: begin
            result_d = dvd_q;
            rmd_d    = neg_out;
            exc_d    = 1'b0;
            state_d  = StDone;
         end
`endif
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         dvd_q     <= '0;
         dvs_q     <= '0;
         rem_q     <= '0;
         cnt_q     <= '0;
         quo_neg_q <= 1'b0;
         rem_neg_q <= 1'b0;
         result_q  <= '0;
         exc_q     <= 1'b0;
`ifdef DIV_REMAINDER_EN
         rmd_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         dvd_q     <= dvd_d;
         dvs_q     <= dvs_d;
         rem_q     <= rem_d;
         cnt_q     <= cnt_d;
         quo_neg_q <= quo_neg_d;
         rem_neg_q <= rem_neg_d;
         result_q  <= result_d;
         exc_q     <= exc_d;
`ifdef DIV_REMAINDER_EN
         rmd_q     <= rmd_d;
`endif
      end
   end

   assign data_result    = result_q;
   assign data_exception = exc_q;
   assign data_resultRDY = (state_q == StDone);
   assign busy           = (state_q != StIdle);
`ifdef DIV_REMAINDER_EN
   assign data_remainder = rmd_q;
`endif

endmodule

// File: tb/tb_signed_div_sequencer.sv
// Scoreboard bench for signed_div_sequencer: accepted starts push a model expectation,
// a monitor pops and compares on every ready pulse (value, exception, latency).
module tb_signed_div_sequencer;

   localparam logic [31:0] MinVal = 32'h8000_0000;

   logic        clock = 1'b0;
   logic        reset;
   logic        ctrl_DIV;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   logic        busy;
`ifdef DIV_REMAINDER_EN
   logic [31:0] data_remainder;
`endif

   signed_div_sequencer #(
      .WIDTH (32)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .ctrl_DIV       (ctrl_DIV),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
`ifdef DIV_REMAINDER_EN
      ,
      .data_remainder (data_remainder)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] res;
      logic        exc;
      logic [31:0] rem;
      int          lat;
      int          start;
   } exp_t;

   exp_t        exp_q[$];
   int          n_vec = 0;
   int          n_fail = 0;
   int          cyc = 0;
   logic [31:0] last_res = '0;
   logic        last_exc = 1'b0;
   bit          prev_rdy = 1'b0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: plain signed arithmetic, C-style truncation; exceptions give zeros.
   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
      exp_t   e;
      longint sa, sb, q, r;
      sa = $signed(a);
      sb = $signed(b);
      e.start = 0;
      if (sb == 0 || (sa == -64'sd2147483648 && sb == -1)) begin
         e.res = '0;
         e.exc = 1'b1;
         e.rem = '0;
         e.lat = 2;
      end else begin
         q = sa / sb;
         r = sa % sb;
         e.res = q[31:0];
         e.exc = 1'b0;
         e.rem = r[31:0];
`ifdef DIV_REMAINDER_EN
         e.lat = 36;
`else
         e.lat = 35;
`endif
      end
      return e;
   endfunction

   // Issue observer: a start is accepted at the next edge when requested while idle.
   always @(negedge clock) begin
      exp_t e;
      if (!reset && ctrl_DIV && !busy) begin
         e = model(data_operandA, data_operandB);
         e.start = cyc + 1;
         exp_q.push_back(e);
      end
   end

   // Monitor: compare on each ready pulse, check holds and idle-after-pulse otherwise.
   always @(negedge clock) begin
      exp_t e;
      if (!reset) begin
         if (data_resultRDY) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_fail++;
               $display("FAIL spurious_rdy: got pulse, expected none (t=%0t)", $time);
            end else begin
               e = exp_q.pop_front();
               check("result", data_result, e.res);
               check("exception", {31'b0, data_exception}, {31'b0, e.exc});
`ifdef DIV_REMAINDER_EN
               check("remainder", data_remainder, e.rem);
`endif
               check("latency", cyc - e.start, e.lat);
            end
            last_res = data_result;
            last_exc = data_exception;
            prev_rdy = 1'b1;
         end else begin
            if (prev_rdy) check("busy_after_rdy", {31'b0, busy}, 32'd0);
            prev_rdy = 1'b0;
            check("result_hold", data_result, last_res);
            check("exc_hold", {31'b0, data_exception}, {31'b0, last_exc});
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      do begin
         @(posedge clock);
         #3;
         n++;
      end while (busy && n < 100);
      if (busy) begin
         n_vec++;
         n_fail++;
         $display("FAIL idle_timeout: busy=%b, expected 0", busy);
      end
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b);
      wait_idle();
      data_operandA = a;
      data_operandB = b;
      ctrl_DIV      = 1'b1;
      @(posedge clock);
      #3;
      ctrl_DIV      = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_result"}, data_result, 32'd0);
      check({tag, "_exc"}, {31'b0, data_exception}, 32'd0);
      check({tag, "_rdy"}, {31'b0, data_resultRDY}, 32'd0);
      check({tag, "_busy"}, {31'b0, busy}, 32'd0);
`ifdef DIV_REMAINDER_EN
      check({tag, "_rem"}, data_remainder, 32'd0);
`endif
   endtask

   initial begin
      int          n;
      logic [31:0] a, b;
      reset         = 1'b1;
      ctrl_DIV      = 1'b0;
      data_operandA = '0;
      data_operandB = '0;
      repeat (2) @(posedge clock);
      #3;
      check_reset_outputs("reset");
      reset = 1'b0;

      issue(32'd7, 32'd2);
      issue(-32'sd7, 32'd2);
      issue(MinVal, 32'd1);
      issue(MinVal, 32'hFFFF_FFFF);
      issue(32'd5, 32'd0);

      // Second request while busy must be ignored.
      issue(32'd100, 32'd7);
      repeat (9) @(posedge clock);
      #3;
      data_operandA = 32'd55;
      data_operandB = 32'd5;
      ctrl_DIV      = 1'b1;
      @(posedge clock);
      #3;
      ctrl_DIV = 1'b0;

      // Request held through the done cycle: only the idle-cycle sample may start.
      issue(32'd20, -32'sd3);
      n = 0;
      do begin
         @(posedge clock);
         #3;
         n++;
      end while (!data_resultRDY && n < 60);
      data_operandA = 32'd11;
      data_operandB = 32'd4;
      ctrl_DIV      = 1'b1;
      @(posedge clock);
      #3;
      @(posedge clock);
      #3;
      ctrl_DIV = 1'b0;

      // Reset mid-operation: immediate clear, no pulse, then a clean division.
      issue(32'd100, 32'd7);
      repeat (20) @(posedge clock);
      #1;
      reset = 1'b1;
      #1;
      check_reset_outputs("midreset");
      exp_q.delete();
      last_res = '0;
      last_exc = 1'b0;
      prev_rdy = 1'b0;
      @(posedge clock);
      #3;
      reset = 1'b0;
      issue(32'd9, 32'd3);

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 5))
            0:       a = MinVal;
            1:       a = $urandom_range(0, 100);
            2:       a = -$urandom_range(1, 100);
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1:       b = 32'hFFFF_FFFF;
            2:       b = MinVal;
            3:       b = $urandom_range(1, 20);
            4:       b = -$urandom_range(1, 20);
            default: b = $urandom;
         endcase
         issue(a, b);
      end

      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 300) begin
         @(posedge clock);
         #3;
         n++;
      end
      repeat (3) @(posedge clock);
      check("drain_pending", exp_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
